ball_cmd_sched: RTL and testbench

- Sits between the USB keycode register and the ball motion datapath; it is the only driver of the ball's key input.
- Converts level-held keycodes into single-frame direction commands and buffers rapid presses in a small FIFO.
- Spaces dispatched commands by a minimum gap.
- Arbitrates ball control between the player and an attract-mode demo pattern that takes over after inactivity.

---
 rtl/ball_cmd_sched_pkg.sv | 34 +++
 rtl/ball_cmd_sched_cmd_fifo.sv | 72 +++++++
 rtl/ball_cmd_sched.sv | 162 ++++++++++++++++
 tb/tb_ball_cmd_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_cmd_sched_pkg.sv
// ball_pkg: shared keycodes, scheduler state type and key helpers for ball_cmd_sched.
package ball_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    // Who currently owns the ball's key input.
    typedef enum logic {
        PLAYER = 1'b0,
        DEMO   = 1'b1
    } state_t;

    // True for the four arrow-key codes; everything else is ignored by the scheduler.
    function automatic logic is_dir_key(input logic [7:0] code);
        return (code == KEY_RIGHT) || (code == KEY_LEFT) ||
               (code == KEY_DOWN)  || (code == KEY_UP);
    endfunction

    // Attract-mode pattern: right, down, left, up.
    function automatic logic [7:0] demo_key(input logic [1:0] idx);
        logic [7:0] code;
        unique case (idx)
            2'd0: code = KEY_RIGHT;
            2'd1: code = KEY_DOWN;
            2'd2: code = KEY_LEFT;
            2'd3: code = KEY_UP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ball_cmd_sched_cmd_fifo.sv
// cmd_fifo: small synchronous FIFO for buffered direction commands.
// A push is accepted when not full, or when a pop frees a slot on the same edge.
// Flush empties the FIFO; a push on the flush edge becomes the only entry.
module cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic [PW-1:0]    wr_addr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Qualify requests against occupancy; a flush restarts writing at slot 0.
    always_comb begin
        do_pop  = pop && !empty && !flush;
        do_push = push && (flush || !full || do_pop);
        wr_addr = flush ? '0 : wr_ptr;
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge frame_clk) begin
        if (do_push) begin
            mem[wr_addr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? PW'(1) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ball_cmd_sched.sv
// ball_cmd_sched: turns held USB keycodes into one-frame ball direction commands,
// buffers rapid presses, enforces a minimum gap between dispatches and, when built
// with BALL_CMD_SCHED_DEMO_EN defined, hands the ball to an attract-mode demo after
// a period of player inactivity.
module ball_cmd_sched
    import ball_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MIN_GAP     = 8,
    parameter int unsigned IDLE_FRAMES = 600,
    parameter int unsigned DEMO_PERIOD = 90
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic [7:0]                 key_in,
    output logic [7:0]                 key_out,
    output logic                       demo_mode,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);

    // Elaboration-time parameter range checks.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ball_cmd_sched: DEPTH must be a power of two in 2..16");
    end
    if (MIN_GAP == 0 || MIN_GAP > 255) begin : g_bad_gap
        $error("ball_cmd_sched: MIN_GAP must be in 1..255");
    end
    if (IDLE_FRAMES == 0 || IDLE_FRAMES > 4095 ||
        DEMO_PERIOD == 0 || DEMO_PERIOD > 255) begin : g_bad_demo
        $error("ball_cmd_sched: IDLE_FRAMES must be 1..4095, DEMO_PERIOD 1..255");
    end

    logic [7:0] key_prev;
    logic [7:0] gap_cnt;
    logic       key_event;
    logic       in_demo;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_flush;
    logic       fifo_full;
    logic       fifo_empty;
    logic       press_drop;
    logic [7:0] fifo_head;

`ifdef BALL_CMD_SCHED_DEMO_EN
    localparam int unsigned IW = $clog2(IDLE_FRAMES + 1);

    state_t        state;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    demo_cnt;
    logic [1:0]    demo_idx;

    assign in_demo = (state == DEMO);
`else
    assign in_demo   = 1'b0;
    assign demo_mode = 1'b0;
`endif

    // Edge detection, FIFO control and overflow qualification for this frame.
    always_comb begin
        key_event  = (key_in != key_prev) && is_dir_key(key_in);
        // A press during the demo discards whatever was queued and restarts from it.
        fifo_flush = in_demo && key_event;
        fifo_pop   = !in_demo && !fifo_empty && (gap_cnt == 8'd0);
        fifo_push  = key_event && (in_demo || !fifo_full || fifo_pop);
        press_drop = key_event && !in_demo && fifo_full && !fifo_pop;
    end

    cmd_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .din       (key_in),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Player dispatch, gap timing, overflow flag and (optionally) the demo FSM.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            key_out  <= KEY_NONE;
            key_prev <= KEY_NONE;
            gap_cnt  <= 8'd0;
            overflow <= 1'b0;
`ifdef BALL_CMD_SCHED_DEMO_EN
            state     <= PLAYER;
            demo_mode <= 1'b0;
            idle_cnt  <= '0;
            demo_cnt  <= 8'd0;
            demo_idx  <= 2'd0;
`endif
        end else begin
            key_prev <= key_in;

            if (press_drop) begin
                overflow <= 1'b1;
            end

            if (fifo_pop) begin
                key_out <= fifo_head;
                gap_cnt <= 8'(MIN_GAP - 1);
            end else begin
                key_out <= KEY_NONE;
                if (fifo_flush) begin
                    gap_cnt <= 8'd0;
                end else if (gap_cnt != 8'd0) begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
            end

`ifdef BALL_CMD_SCHED_DEMO_EN
            if (key_event) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IW'(IDLE_FRAMES)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            case (state)
                PLAYER: begin
                    // Only take over with nothing queued, so no player command is lost.
                    if ((idle_cnt == IW'(IDLE_FRAMES - 1)) && !key_event && fifo_empty) begin
                        state     <= DEMO;
                        demo_mode <= 1'b1;
                        demo_cnt  <= 8'd0;
                        demo_idx  <= 2'd0;
                    end
                end
                DEMO: begin
                    if (key_event) begin
                        // The press wins; key_out stays 0 and the press goes out next edge.
                        state     <= PLAYER;
                        demo_mode <= 1'b0;
                    end else begin
                        if (demo_cnt == 8'd0) begin
                            key_out  <= demo_key(demo_idx);
                            demo_idx <= demo_idx + 2'd1;
                        end
                        if (demo_cnt == 8'(DEMO_PERIOD - 1)) begin
                            demo_cnt <= 8'd0;
                        end else begin
                            demo_cnt <= demo_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state     <= PLAYER;
                    demo_mode <= 1'b0;
                end
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_ball_cmd_sched.sv
// Self-checking bench for ball_cmd_sched: directed scenarios plus a randomized
// run, all compared against a frame-level behavioural model built on a queue.
module tb_ball_cmd_sched;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned MIN_GAP     = 8;
    localparam int unsigned IDLE_FRAMES = 10;
    localparam int unsigned DEMO_PERIOD = 5;
    localparam int unsigned CW          = $clog2(DEPTH + 1);

    logic          frame_clk = 1'b0;
    logic          Reset     = 1'b0;
    logic [7:0]    key_in    = 8'h00;
    logic [7:0]    key_out;
    logic          demo_mode;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    ball_cmd_sched #(
        .DEPTH       (DEPTH),
        .MIN_GAP     (MIN_GAP),
        .IDLE_FRAMES (IDLE_FRAMES),
        .DEMO_PERIOD (DEMO_PERIOD)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .key_in     (key_in),
        .key_out    (key_out),
        .demo_mode  (demo_mode),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 frame_clk = ~frame_clk;

    // Behavioural model state.
    logic [7:0] m_q [$];
    logic [7:0] m_prev;
    logic [7:0] m_out;
    int         m_gap;
    int         m_idle;
    int         m_dcnt;
    int         m_didx;
    bit         m_demo;
    bit         m_ovf;
    logic [7:0] demo_seq [4] = '{8'h4F, 8'h51, 8'h50, 8'h52};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_prev = 8'h00;
        m_out  = 8'h00;
        m_gap  = 0;
        m_idle = 0;
        m_dcnt = 0;
        m_didx = 0;
        m_demo = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    // One frame of the scheduler's rules, evaluated on pre-edge state.
    function automatic void model_edge(input logic [7:0] k);
        bit ev;
        bit pre_empty;
        ev        = (k != m_prev) && (k inside {[8'h4F:8'h52]});
        m_prev    = k;
        pre_empty = (m_q.size() == 0);
        m_out     = 8'h00;
        if (m_demo) begin
            if (ev) begin
                m_demo = 1'b0;
                m_q.delete();
                m_q.push_back(k);
                m_gap = 0;
            end else begin
                if (m_dcnt == 0) begin
                    m_out  = demo_seq[m_didx];
                    m_didx = (m_didx + 1) % 4;
                end
                m_dcnt = (m_dcnt + 1) % DEMO_PERIOD;
            end
        end else begin
            if (!pre_empty && m_gap == 0) begin
                m_out = m_q.pop_front();
                m_gap = MIN_GAP - 1;
            end else if (m_gap > 0) begin
                m_gap--;
            end
            if (ev) begin
                if (m_q.size() < DEPTH) m_q.push_back(k);
                else m_ovf = 1'b1;
            end
`ifdef BALL_CMD_SCHED_DEMO_EN
            if (m_idle == IDLE_FRAMES - 1 && !ev && pre_empty) begin
                m_demo = 1'b1;
                m_dcnt = 0;
                m_didx = 0;
            end
`endif
        end
        if (ev) m_idle = 0;
        else if (m_idle < IDLE_FRAMES) m_idle++;
    endfunction

    // Drive one frame, advance the model and compare all outputs 1 time unit after the edge.
    task automatic step(input logic [7:0] k);
        key_in = k;
        @(posedge frame_clk);
        model_edge(k);
        #1;
        check("model key_out", key_out, m_out);
        check("model demo_mode", demo_mode, m_demo);
        check("model fifo_count", fifo_count, m_q.size());
        check("model overflow", overflow, m_ovf);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        key_in = 8'h00;
        Reset  = 1'b1;
        #1;
        check("rst key_out", key_out, 8'h00);
        check("rst fifo_count", fifo_count, 0);
        check("rst overflow", overflow, 1'b0);
        check("rst demo_mode", demo_mode, 1'b0);
        model_reset();
        @(posedge frame_clk);
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        logic [7:0] codes [7] = '{8'h00, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h04, 8'h29};
        logic [7:0] seq6 [6] = '{8'h4F, 8'h50, 8'h4F, 8'h50, 8'h4F, 8'h50};
        int peak;

        model_reset();
        #1;
        Reset = 1'b1;
        #11;
        check("reset key_out", key_out, 8'h00);
        check("reset demo_mode", demo_mode, 1'b0);
        check("reset fifo_count", fifo_count, 0);
        check("reset overflow", overflow, 1'b0);
        Reset = 1'b0;

        // Held key: exactly one command at the edge after the event.
        step(8'h00);
        step(8'h52);
        check("hold pre key_out", key_out, 8'h00);
        check("hold pushed", fifo_count, 1);
        step(8'h52);
        check("hold dispatch", key_out, 8'h52);
        check("hold fifo empty", fifo_count, 0);
        for (int i = 0; i < 8; i++) begin
            step(8'h52);
            check("hold no repeat", key_out, 8'h00);
        end
        for (int i = 0; i < 10; i++) step(8'h52);
        step(8'h00);

        // Three presses on consecutive frames, spaced by MIN_GAP.
        do_reset();
        peak = 0;
        step(8'h4F);
        step(8'h51);
        check("gap first", key_out, 8'h4F);
        step(8'h50);
        for (int i = 3; i <= 17; i++) begin
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            step(8'h00);
            if (i == 9) check("gap second", key_out, 8'h51);
            else if (i == 17) check("gap third", key_out, 8'h50);
            else check("gap quiet", key_out, 8'h00);
        end
        check("gap peak count", peak, 2);
        check("gap drained", fifo_count, 0);

        // Six alternating presses: one dispatched, four buffered, one dropped.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(seq6[i]);
            if (i == 1) check("ovf dispatch", key_out, 8'h4F);
            if (i == 4) check("ovf not yet", overflow, 1'b0);
        end
        check("ovf set", overflow, 1'b1);
        check("ovf full", fifo_count, DEPTH);
        for (int i = 0; i < 40; i++) step(8'h00);
        check("ovf sticky", overflow, 1'b1);

        // Reset asserted while a command is being dispatched with 3 buffered.
        do_reset();
        for (int i = 0; i < 5; i++) step(seq6[i]);
        for (int i = 5; i <= 9; i++) step(8'h00);
        check("mid dispatch key", key_out, 8'h50);
        check("mid dispatch count", fifo_count, 3);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(8'h00);
            check("post reset quiet", key_out, 8'h00);
        end

`ifdef BALL_CMD_SCHED_DEMO_EN
        // Demo takeover after IDLE_FRAMES and the demo pattern.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(8'h00);
            if (i == 9) check("demo not yet", demo_mode, 1'b0);
        end
        check("demo entered", demo_mode, 1'b1);
        for (int i = 11; i <= 31; i++) begin
            step(8'h00);
            if ((i - 11) % 5 == 0) check("demo cmd", key_out, demo_seq[((i - 11) / 5) % 4]);
            else check("demo quiet", key_out, 8'h00);
        end
        for (int i = 32; i <= 35; i++) step(8'h00);
        step(8'h50);
        check("demo preempt key", key_out, 8'h00);
        check("demo preempt mode", demo_mode, 1'b0);
        step(8'h50);
        check("demo preempt dispatch", key_out, 8'h50);
`else
        do_reset();
        for (int i = 0; i < 3 * IDLE_FRAMES; i++) step(8'h00);
        check("no demo build", demo_mode, 1'b0);
        check("no demo key", key_out, 8'h00);
`endif

        // Randomized holds of mixed codes, with one asynchronous reset midway.
        do_reset();
        for (int n = 0; n < 120; n++) begin
            logic [7:0] code;
            int hold;
            code = codes[$urandom_range(0, 6)];
            hold = (code == 8'h00) ? $urandom_range(1, 14) : $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) step(code);
            if (n == 60) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
